perf_pipe_sched: RTL and testbench

- Collects per-stage valid/stall activity from up to NUM_STAGES pipeline stages into windowed counters.
- Once per window, snapshots all counters and serializes one report per stage onto a single shared reporting port with a valid/ready handshake.
- Downstream is the single DPI perf sink. Upstream is the pipeline stage valid/stall wires.
- Sits beside the core pipeline; never affects datapath timing.

---
 rtl/perf_pipe_pkg.sv | 13 +
 rtl/perf_pipe_sched_stage_counter.sv | 48 ++++
 rtl/perf_pipe_sched.sv | 141 ++++++++++++++
 tb/tb_perf_pipe_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pipe_pkg.sv
// perf_pipe_sched shared types and constants.
// Imported by the scheduler top and its helpers.
package perf_pipe_pkg;

    typedef enum logic {
        IDLE,
        DUMP
    } perf_state_t;

    localparam int RPT_ID_W = 8;
    localparam int OVR_W    = 16;

endpackage

// File: rtl/perf_pipe_sched_stage_counter.sv
// perf_stage_counter: one stage's live and shadow valid/stall counters.
// Live counters saturate; snap copies live+increment to shadow and clears live.
module perf_stage_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_valid,
    input  logic                 inc_stall,
    input  logic                 snap,
    output logic [CNT_WIDTH-1:0] shadow_valid,
    output logic [CNT_WIDTH-1:0] shadow_stall
);

    logic [CNT_WIDTH-1:0] live_valid;
    logic [CNT_WIDTH-1:0] live_stall;
    logic [CNT_WIDTH-1:0] nxt_valid;
    logic [CNT_WIDTH-1:0] nxt_stall;

    // Saturating next-count including this cycle's sample.
    always_comb begin
        nxt_valid = live_valid;
        nxt_stall = live_stall;
        if (inc_valid && (live_valid != '1))
            nxt_valid = live_valid + CNT_WIDTH'(1);
        if (inc_stall && (live_stall != '1))
            nxt_stall = live_stall + CNT_WIDTH'(1);
    end

    // Accumulate, or hand the window total to shadow and restart.
    always_ff @(posedge clk) begin
        if (!rst) begin
            live_valid   <= '0;
            live_stall   <= '0;
            shadow_valid <= '0;
            shadow_stall <= '0;
        end else if (snap) begin
            live_valid   <= '0;
            live_stall   <= '0;
            shadow_valid <= nxt_valid;
            shadow_stall <= nxt_stall;
        end else begin
            live_valid   <= nxt_valid;
            live_stall   <= nxt_stall;
        end
    end

endmodule

// File: rtl/perf_pipe_sched.sv
// perf_pipe_sched: windowed per-stage activity counters, serialized report port.
// Define PERF_PIPE_SKIP_ZERO_EN to skip stages whose window counts are all zero.
module perf_pipe_sched
    import perf_pipe_pkg::*;
#(
    parameter int NUM_STAGES = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int PERIOD     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stage_valid,
    input  logic [NUM_STAGES-1:0] stage_stall,
    input  logic                  flush_req,
    output logic                  rpt_valid,
    input  logic                  rpt_ready,
    output logic [RPT_ID_W-1:0]   rpt_id,
    output logic [CNT_WIDTH-1:0]  rpt_valid_cnt,
    output logic [CNT_WIDTH-1:0]  rpt_stall_cnt,
    output logic                  busy,
    output logic [OVR_W-1:0]      overrun_cnt
);

    typedef struct packed {
        logic [CNT_WIDTH-1:0] valid_cnt;
        logic [CNT_WIDTH-1:0] stall_cnt;
    } perf_cnt_pair_t;

    localparam int WIN_W = $clog2(PERIOD);
    localparam logic [WIN_W-1:0]    WIN_LAST = WIN_W'(PERIOD - 1);
    localparam logic [RPT_ID_W-1:0] LAST_ID  = RPT_ID_W'(NUM_STAGES - 1);

    perf_state_t          state;
    logic [RPT_ID_W-1:0]  idx;
    logic [RPT_ID_W-1:0]  cur;
    logic                 found;
    logic                 close;
    logic                 snap;
    logic                 xfer;
    logic [WIN_W-1:0]     win;
    perf_cnt_pair_t       shadow [NUM_STAGES];
    perf_cnt_pair_t       sel;

    assign close = flush_req || (win == WIN_LAST);
    assign snap  = close && (state == IDLE);

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        perf_stage_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk          (clk),
            .rst          (rst),
            .inc_valid    (stage_valid[g]),
            .inc_stall    (stage_stall[g]),
            .snap         (snap),
            .shadow_valid (shadow[g].valid_cnt),
            .shadow_stall (shadow[g].stall_cnt)
        );
    end

    // Pick the stage to report: idx itself, or the next non-zero one.
    always_comb begin
        cur   = idx;
        found = 1'b1;
`ifdef PERF_PIPE_SKIP_ZERO_EN
        found = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if ((RPT_ID_W'(i) >= idx) && (shadow[i] != '0)) begin
                cur   = RPT_ID_W'(i);
                found = 1'b1;
            end
        end
`endif
    end

    // Mux the selected shadow pair onto the report port.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (RPT_ID_W'(i) == cur)
                sel = shadow[i];
        end
    end

    assign busy          = (state == DUMP);
    assign rpt_valid     = busy && found;
    assign rpt_id        = rpt_valid ? cur : '0;
    assign rpt_valid_cnt = rpt_valid ? sel.valid_cnt : '0;
    assign rpt_stall_cnt = rpt_valid ? sel.stall_cnt : '0;
    assign xfer          = rpt_valid && rpt_ready;

    // Window position; a flush restarts the window.
    always_ff @(posedge clk) begin
        if (!rst)
            win <= '0;
        else if (close)
            win <= '0;
        else
            win <= win + WIN_W'(1);
    end

    // Dump sequencer: walk the stages once per snapshot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (close) begin
                        state <= DUMP;
                        idx   <= '0;
                    end
                end
                DUMP: begin
                    if (!found) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else if (xfer) begin
                        if (cur == LAST_ID) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= cur + RPT_ID_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Count windows lost because a dump was still running.
    always_ff @(posedge clk) begin
        if (!rst)
            overrun_cnt <= '0;
        else if (close && busy && (overrun_cnt != '1))
            overrun_cnt <= overrun_cnt + OVR_W'(1);
    end

endmodule

// File: tb/tb_perf_pipe_sched.sv
// Randomized scoreboard bench for perf_pipe_sched.
// A queue-based window model predicts every report beat.
module tb_perf_pipe_sched;

    localparam int N    = 4;
    localparam int CW   = 5;
    localparam int PER  = 16;
    localparam int MAXC = (1 << CW) - 1;
`ifdef PERF_PIPE_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  sv = '0;
    logic [N-1:0]  ss = '0;
    logic          flush = 1'b0;
    logic          rdy = 1'b0;
    logic          rpt_valid;
    logic [7:0]    rpt_id;
    logic [CW-1:0] rpt_valid_cnt;
    logic [CW-1:0] rpt_stall_cnt;
    logic          busy;
    logic [15:0]   overrun_cnt;

    perf_pipe_sched #(
        .NUM_STAGES (N),
        .CNT_WIDTH  (CW),
        .PERIOD     (PER)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stage_valid   (sv),
        .stage_stall   (ss),
        .flush_req     (flush),
        .rpt_valid     (rpt_valid),
        .rpt_ready     (rdy),
        .rpt_id        (rpt_id),
        .rpt_valid_cnt (rpt_valid_cnt),
        .rpt_stall_cnt (rpt_stall_cnt),
        .busy          (busy),
        .overrun_cnt   (overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int v;
        int s;
    } beat_t;

    beat_t exp_q[$];
    beat_t pend_q[$];
    int    live_v[N];
    int    live_s[N];
    int    win;
    int    ovr;
    bit    tail;
    bit    mon_en = 1'b0;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    // Reference model: window totals as plain integer sums.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    live_v[i] = 0;
                    live_s[i] = 0;
                end
                win  = 0;
                ovr  = 0;
                tail = 1'b0;
                pend_q.delete();
                exp_q.delete();
            end else begin
                automatic bit    cl = flush || (win == PER - 1);
                automatic bit    bz = (pend_q.size() > 0) || tail;
                automatic bit    tn = 1'b0;
                automatic int    cnt = 0;
                automatic int    nv[N];
                automatic int    ns[N];
                automatic beat_t b;
                for (int i = 0; i < N; i++) begin
                    nv[i] = sat(live_v[i] + int'(sv[i]));
                    ns[i] = sat(live_s[i] + int'(ss[i]));
                end
                if ((pend_q.size() > 0) && rdy) begin
                    b = pend_q.pop_front();
                    if ((pend_q.size() == 0) && (b.id != N - 1))
                        tn = 1'b1;
                end
                if (cl && bz && (ovr < 65535))
                    ovr = ovr + 1;
                if (cl && !bz) begin
                    for (int i = 0; i < N; i++) begin
                        if (!(SKIP && (nv[i] == 0) && (ns[i] == 0))) begin
                            b = '{i, nv[i], ns[i]};
                            pend_q.push_back(b);
                            exp_q.push_back(b);
                            cnt++;
                        end
                        nv[i] = 0;
                        ns[i] = 0;
                    end
                    if (cnt == 0)
                        tn = 1'b1;
                end
                for (int i = 0; i < N; i++) begin
                    live_v[i] = nv[i];
                    live_s[i] = ns[i];
                end
                tail = tn;
                win  = cl ? 0 : win + 1;
            end
        end
    end

    // Monitor: compare presented beats against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && mon_en) begin
                chk("busy", 32'(busy), 32'((pend_q.size() > 0) || tail));
                chk("overrun", 32'(overrun_cnt), 32'(ovr));
                chk("valid", 32'(rpt_valid), 32'(pend_q.size() > 0));
                if (rpt_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat id=%0d t=%0t",
                                 rpt_id, $time);
                    end else begin
                        chk("rpt_id", 32'(rpt_id), 32'(exp_q[0].id));
                        chk("valid_cnt", 32'(rpt_valid_cnt), 32'(exp_q[0].v));
                        chk("stall_cnt", 32'(rpt_stall_cnt), 32'(exp_q[0].s));
                        if (rdy)
                            void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset();
        @(negedge clk);
        chk("rst_valid", 32'(rpt_valid), 32'd0);
        chk("rst_id", 32'(rpt_id), 32'd0);
        chk("rst_vcnt", 32'(rpt_valid_cnt), 32'd0);
        chk("rst_scnt", 32'(rpt_stall_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(overrun_cnt), 32'd0);
    endtask

    task automatic rand_run(input int n);
        repeat (n) begin
            sv    = N'($urandom);
            ss    = N'($urandom);
            rdy   = ($urandom_range(3) != 0);
            flush = ($urandom_range(49) == 0);
            step(1);
        end
        flush = 1'b0;
    endtask

    initial begin
        bit hit;
        step(3);
        chk_reset();
        step(1);
        rst    = 1'b1;
        mon_en = 1'b1;

        sv  = 4'b0100;
        ss  = '0;
        rdy = 1'b1;
        step(24);

        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if ((pend_q.size() > 0) && (pend_q[0].id == 1)) begin
                hit = 1'b1;
                rdy = 1'b0;
                step(5);
                rdy = 1'b1;
            end else begin
                step(1);
            end
        end
        chk("stall_window_seen", 32'(hit), 32'd1);
        step(20);

        sv  = 4'b0001;
        ss  = 4'b0010;
        rdy = 1'b0;
        step(3 * PER);
        rdy = 1'b1;
        step(3 * PER);

        sv = 4'b0001;
        ss = '0;
        step(5);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(2 * PER);

        sv = 4'b1000;
        ss = '0;
        step(3 * PER);
        sv = '0;
        step(3 * PER);

        rand_run(1500);

        hit = 1'b0;
        rdy = 1'b0;
        sv  = 4'b0110;
        for (int k = 0; k < 3 * PER && !hit; k++) begin
            if (pend_q.size() > 0)
                hit = 1'b1;
            else
                step(1);
        end
        chk("dump_before_reset", 32'(hit), 32'd1);
        rst    = 1'b0;
        mon_en = 1'b0;
        step(1);
        chk_reset();
        step(1);
        rst    = 1'b1;
        mon_en = 1'b1;

        rand_run(300);
        sv  = '0;
        ss  = '0;
        rdy = 1'b1;
        step(3 * PER);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(pend_q.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
